// File: rtl/mux_n_staged.sv
// -----------------------------------------------------------------------------
// mux_n_staged
//
// Registered N-way valid/ready multiplexer. It picks one producer channel per
// cycle and loads that channel's word into a one-deep output register. The
// channel is chosen either explicitly (mode=0, by S) or round-robin (mode=1).
// With a ready consumer it moves one word per cycle, without bubbles.
//
// Ports
//   CLK          clock; all state updates on the rising edge
//   ASYNCRESETN  asynchronous active-low reset
//   I            channel data; channel k occupies I[k*WIDTH +: WIDTH]
//   I_valid      per-channel valid
//   I_ready      per-channel ready (combinational)
//   S            explicit channel select, used when mode=0
//   mode         0 = explicit select via S, 1 = round-robin
//   O            registered output data
//   O_valid      output register holds a word
//   O_ready      consumer accepts the word
//   O_sel        channel index of the word currently held in O
// -----------------------------------------------------------------------------
module mux_n_staged #(
  parameter int WIDTH = 2,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic [N*WIDTH-1:0]   I,
  input  logic [N-1:0]         I_valid,
  output logic [N-1:0]         I_ready,
  input  logic [SELW-1:0]      S,
  input  logic                 mode,
  output logic [WIDTH-1:0]     O,
  output logic                 O_valid,
  input  logic                 O_ready,
  output logic [SELW-1:0]      O_sel
);

  logic [WIDTH-1:0] chan [N];   // unpacked view of the flat data bus
  logic [SELW-1:0]  ptr;        // round-robin start point
  logic [SELW-1:0]  cand;       // candidate channel this cycle
  logic [SELW-1:0]  rr_idx;
  logic             has_cand;
  logic             can_accept;
  logic             xfer;

  for (genvar k = 0; k < N; k++) begin : g_chan
    assign chan[k] = I[k*WIDTH +: WIDTH];
  end

  // The output register can take a new word when it is empty, or when its
  // current word leaves in this same cycle.
  assign can_accept = !O_valid || O_ready;

  // Candidate selection.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the block leaves a value held and no latch is inferred.
    cand     = '0;
    has_cand = 1'b0;
    rr_idx   = '0;
    if (!mode) begin
      // An out-of-range select names no channel at all.
      if (int'(S) < N) begin
        cand     = S;
        has_cand = 1'b1;
      end
    end else begin
      // Scan ptr, ptr+1, ... (mod N); the first valid channel wins.
      for (int i = 0; i < N; i++) begin
        rr_idx = SELW'((int'(ptr) + i) % N);
        if (!has_cand && I_valid[rr_idx]) begin
          cand     = rr_idx;
          has_cand = 1'b1;
        end
      end
    end
  end

  always_comb begin
    I_ready = '0;
    for (int k = 0; k < N; k++) begin
      I_ready[k] = can_accept && has_cand && (cand == SELW'(k));
    end
  end

  assign xfer = has_cand && can_accept && I_valid[cand];

  // Output register and round-robin pointer.
  // NOTE: reset clears every state bit, so a word held when reset arrives is
  // dropped rather than delivered late.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      O       <= '0;
      O_valid <= 1'b0;
      O_sel   <= '0;
      ptr     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, whatever the statement order.
      if (xfer) begin
        // A drain and a fill in the same cycle go through this branch too,
        // so O_valid stays high with no bubble.
        O       <= chan[cand];
        O_sel   <= cand;
        O_valid <= 1'b1;
      end else if (O_ready) begin
        // Drained with nothing behind it; data and index keep their values.
        O_valid <= 1'b0;
      end
      // The pointer moves only on round-robin grants, so it keeps its value
      // across explicit-mode stretches.
      if (xfer && mode) begin
        ptr <= (int'(cand) == N - 1) ? '0 : cand + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_staged.sv
// -----------------------------------------------------------------------------
// tb_mux_n_staged
//
// Directed bench for mux_n_staged. It uses three instances: the default
// 4-channel by 2-bit block, a 3-channel block for the out-of-range select, and
// a 2-channel by 1-bit block for the plain bit-mux case. Expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mux_n_staged;

  logic CLK = 1'b0;
  logic ASYNCRESETN;

  always #5 CLK = ~CLK;

  // Instance A: N=4, WIDTH=2
  logic [7:0] a_i;
  logic [3:0] a_i_valid, a_i_ready;
  logic [1:0] a_s, a_o, a_o_sel;
  logic       a_mode, a_o_valid, a_o_ready;

  // Instance B: N=3, WIDTH=2, SELW=2
  logic [5:0] b_i;
  logic [2:0] b_i_valid, b_i_ready;
  logic [1:0] b_s, b_o, b_o_sel;
  logic       b_mode, b_o_valid, b_o_ready;

  // Instance C: N=2, WIDTH=1, SELW=1
  logic [1:0] c_i, c_i_valid, c_i_ready;
  logic       c_s, c_o, c_o_sel;
  logic       c_mode, c_o_valid, c_o_ready;

  mux_n_staged #(.WIDTH(2), .N(4)) dut_a (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .I(a_i), .I_valid(a_i_valid), .I_ready(a_i_ready),
    .S(a_s), .mode(a_mode),
    .O(a_o), .O_valid(a_o_valid), .O_ready(a_o_ready), .O_sel(a_o_sel)
  );

  mux_n_staged #(.WIDTH(2), .N(3)) dut_b (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .I(b_i), .I_valid(b_i_valid), .I_ready(b_i_ready),
    .S(b_s), .mode(b_mode),
    .O(b_o), .O_valid(b_o_valid), .O_ready(b_o_ready), .O_sel(b_o_sel)
  );

  mux_n_staged #(.WIDTH(1), .N(2)) dut_c (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .I(c_i), .I_valid(c_i_valid), .I_ready(c_i_ready),
    .S(c_s), .mode(c_mode),
    .O(c_o), .O_valid(c_o_valid), .O_ready(c_o_ready), .O_sel(c_o_sel)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and then sample 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic       s_seq  [4];
  logic       o_seq  [4];
  logic [1:0] rr_exp [4];

  initial begin
    a_i = {2'd3, 2'd2, 2'd1, 2'd0};
    a_i_valid = '0; a_s = '0; a_mode = 1'b0; a_o_ready = 1'b0;
    b_i = {2'd2, 2'd1, 2'd0};
    b_i_valid = '0; b_s = '0; b_mode = 1'b0; b_o_ready = 1'b0;
    c_i = 2'b10;
    c_i_valid = '0; c_s = 1'b0; c_mode = 1'b0; c_o_ready = 1'b0;

    // Reset state.
    ASYNCRESETN = 1'b0;
    #2;
    check("reset_o",       a_o,       0);
    check("reset_o_valid", a_o_valid, 0);
    check("reset_o_sel",   a_o_sel,   0);
    #1 ASYNCRESETN = 1'b1;
    tick();

    // Explicit select: S=2, all valid.
    a_mode = 1'b0; a_s = 2'd2; a_i_valid = 4'hF; a_o_ready = 1'b1;
    #1 check("expl_i_ready", a_i_ready, 4'b0100);
    tick();
    check("expl_o",       a_o,       2);
    check("expl_o_sel",   a_o_sel,   2);
    check("expl_o_valid", a_o_valid, 1);

    // Backpressure: the word stays frozen and every ready bit is low.
    a_o_ready = 1'b0;
    #1 check("stall_i_ready0", a_i_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_o",       a_o,       2);
      check("stall_o_valid", a_o_valid, 1);
      check("stall_i_ready", a_i_ready, 0);
    end

    // Release with S=1: drain and fill happen in the same cycle.
    a_s = 2'd1; a_o_ready = 1'b1;
    #1 check("fill_i_ready", a_i_ready, 4'b0010);
    tick();
    check("fill_o",       a_o,       1);
    check("fill_o_sel",   a_o_sel,   1);
    check("fill_o_valid", a_o_valid, 1);

    // Round-robin with every channel valid, starting from ptr=0.
    a_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rr_all_o_sel",   a_o_sel,   i % 4);
      check("rr_all_o",       a_o,       i % 4);
      check("rr_all_o_valid", a_o_valid, 1);
    end

    // Round-robin with only channels 1 and 3 valid.
    a_i_valid = 4'b1010;
    rr_exp[0] = 2'd1; rr_exp[1] = 2'd3; rr_exp[2] = 2'd1; rr_exp[3] = 2'd3;
    for (int i = 0; i < 4; i++) begin
      #1 check("rr_sparse_i_ready", a_i_ready, 4'b0001 << rr_exp[i]);
      tick();
      check("rr_sparse_o_sel", a_o_sel, rr_exp[i]);
    end

    // Nothing valid: the held word drains and O keeps its last value.
    a_i_valid = 4'b0000;
    #1 check("idle_i_ready", a_i_ready, 0);
    tick();
    check("drain_o_valid", a_o_valid, 0);
    check("drain_o",       a_o,       3);
    check("drain_o_sel",   a_o_sel,   3);

    // Move ptr away from 0, then load 3 in explicit mode and stall.
    a_i_valid = 4'b0100;
    tick();
    check("rr_single_o_sel", a_o_sel, 2);
    a_mode = 1'b0; a_s = 2'd3; a_i_valid = 4'hF;
    tick();
    check("pre_rst_o",       a_o,       3);
    check("pre_rst_o_valid", a_o_valid, 1);
    a_o_ready = 1'b0;

    // Reset between edges clears the output immediately.
    #2 ASYNCRESETN = 1'b0;
    #1;
    check("midrst_o",       a_o,       0);
    check("midrst_o_valid", a_o_valid, 0);
    check("midrst_o_sel",   a_o_sel,   0);
    #1 ASYNCRESETN = 1'b1;

    // After release the round-robin scan starts again from channel 0.
    a_mode = 1'b1; a_o_ready = 1'b1;
    #1 check("post_rst_i_ready", a_i_ready, 4'b0001);
    tick();
    check("post_rst_o_sel",   a_o_sel,   0);
    check("post_rst_o_valid", a_o_valid, 1);
    a_i_valid = '0;

    // Out-of-range select on the 3-channel block.
    b_mode = 1'b0; b_s = 2'd2; b_i_valid = 3'b111; b_o_ready = 1'b1;
    #1 check("oor_pre_i_ready", b_i_ready, 3'b100);
    tick();
    check("oor_pre_o",       b_o,       2);
    check("oor_pre_o_valid", b_o_valid, 1);
    b_s = 2'd3;
    #1 check("oor_i_ready", b_i_ready, 0);
    tick();
    check("oor_o_valid", b_o_valid, 0);
    check("oor_o",       b_o,       2);
    tick();
    check("oor_o_valid_hold", b_o_valid, 0);

    // Two-input bit mux, one cycle late.
    c_mode = 1'b0; c_i_valid = 2'b11; c_o_ready = 1'b1;
    s_seq[0] = 1'b0; s_seq[1] = 1'b1; s_seq[2] = 1'b1; s_seq[3] = 1'b0;
    o_seq[0] = 1'b0; o_seq[1] = 1'b1; o_seq[2] = 1'b1; o_seq[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c_s = s_seq[i];
      tick();
      check("bitmux_o",       c_o,       o_seq[i]);
      check("bitmux_o_valid", c_o_valid, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_n_staged.md
Name: mux_n_staged

Overview:
- Registered N-way valid/ready multiplexer.
- Generalises the two-input combinational Bits/Bit mux in three ways: the input count and data width are parameters; a one-deep output pipeline register is added; an optional round-robin selection mode is added alongside explicit select.
- Sits between producer channels and a single downstream consumer in generated datapaths.

Parameters:
- WIDTH, 2, data width of each channel and of the output.
- N, 4, number of input channels (N >= 2).
- SELW, clog2(N), width of the select and channel-ID fields.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- ASYNCRESETN  input  1  reset, asynchronous, active-low.
- I  input  N*WIDTH  channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- I_valid  input  N  per-channel valid.
- I_ready  output  N  per-channel ready (combinational).
- S  input  SELW  explicit channel select, used when mode=0.
- mode  input  1  0 = explicit select via S; 1 = round-robin.
- O  output  WIDTH  registered output data.
- O_valid  output  1  output register holds a word.
- O_ready  input  1  consumer accepts the word.
- O_sel  output  SELW  channel index of the word currently held in O.

Behaviour:
- Reset (ASYNCRESETN low, asynchronous): O=0, O_valid=0, O_sel=0, round-robin pointer ptr=0. A word held at reset is discarded.
- can_accept = !O_valid || O_ready. Full throughput: one word per cycle while the consumer is ready.
- Explicit mode (mode=0):
  - Candidate channel c = S.
  - If S >= N, there is no candidate; all I_ready bits are 0.
- Round-robin mode (mode=1):
  - c is the first k in the sequence ptr, ptr+1, …, wrapping mod N, for which I_valid[k]=1.
  - If no channel is valid, there is no candidate.
- I_ready[k] = can_accept && (k == c). All other I_ready bits are 0. I_ready never depends on O_valid alone.
- Transfer occurs when I_valid[c] && I_ready[c]. On the next rising edge: O <= channel c data, O_sel <= c, O_valid <= 1.
- Round-robin pointer update: on a transfer in mode=1, ptr <= (c+1) mod N, wrapping from N-1 to 0. In every other cycle ptr holds. This includes all mode=0 cycles, so ptr is retained across mode switches.
- Emptying: if O_valid && O_ready and there is no transfer in the same cycle, O_valid <= 0. O and O_sel keep their last values.
- Simultaneous drain and fill (O_valid && O_ready && transfer): the new word is loaded and O_valid stays 1. No bubble is inserted.
- Stall: while O_valid && !O_ready, the values of O, O_sel and O_valid are frozen, and all I_ready bits are 0.
- Latency: exactly 1 cycle from input handshake to O_valid.
- mode and S are sampled combinationally every cycle. A change takes effect in the same cycle's grant.
- Degenerate case N=2, WIDTH=1, mode=0 with O_ready tied to 1: behaves as the two-input Bit mux (O = S ? I1 : I0) delayed by one cycle.

Test Plan:
- Explicit select: N=4, WIDTH=2, mode=0, S=2, all I_valid=1, channel data {0,1,2,3}, O_ready=1 -> I_ready=4'b0100; one cycle later O=2'h2, O_sel=2, O_valid=1.
- Backpressure: hold O_ready=0 for 3 cycles after O=2'h2 -> O stays 2'h2 and I_ready=0 throughout. Raise O_ready with S=1 -> same-cycle drain and fill; next cycle O=2'h1 with no bubble.
- Round-robin fairness: mode=1, all valid, O_ready=1 for 8 cycles -> O_sel sequence 0,1,2,3,0,1,2,3. Then only I_valid[1] and I_valid[3] high, starting from ptr=0 -> grants 1,3,1,3.
- Out-of-range select: N=3 (SELW=2), mode=0, S=3 -> I_ready=0 and O_valid falls to 0 after the pending word drains.
- Reset mid-operation: O_valid=1 holding 2'h3 while O_ready=0; pulse ASYNCRESETN low between clock edges -> O=0, O_valid=0, O_sel=0 immediately. After release in mode=1, the first grant starts from channel 0.
- Degenerate Bit mux: N=2, WIDTH=1, I0=0, I1=1, O_ready=1; toggle S=0,1,1,0 -> O=0,1,1,0, each one cycle later.
